// File: rtl/spi_slave_rx_pkg.sv
// Shared defaults and types for the SPI slave receiver.
// Holds word geometry, synchronizer reset levels and the receiver state encoding.
package spi_slave_rx_pkg;

  localparam int unsigned DataWDef      = 16;
  localparam int unsigned NumWordsDef   = 32;
  localparam int unsigned IdxWDef       = 5;
  localparam int unsigned SyncStagesDef = 2;

  localparam logic SpiClkIdle = 1'b0;
  localparam logic SyncRstClk = SpiClkIdle;
  localparam logic SyncRstCsn = 1'b1;
  localparam logic SyncRstSdi = 1'b0;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } rx_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// SPI pins plus the received-word side of the SPI slave receiver.
// The master modport drives the SPI lines and observes the receiver outputs.
interface spi_slave_rx_if
  import spi_slave_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned IDX_W  = IdxWDef
);
  logic              spi_clk;
  logic              spi_csn;
  logic              spi_sdi;
  logic              spi_sdo;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [IDX_W-1:0]  rx_index;
  logic              rx_done;
  logic              frame_err;

  modport master (
    output spi_clk, spi_csn, spi_sdi,
    input  spi_sdo, rx_data, rx_valid, rx_index, rx_done, frame_err
  );

  modport slave (
    input  spi_clk, spi_csn, spi_sdi,
    output spi_sdo, rx_data, rx_valid, rx_index, rx_done, frame_err
  );
endinterface

// File: rtl/spi_slave_rx_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset level.
module spi_slave_rx_sync #(
  parameter int unsigned Stages = 2,
  parameter logic        RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {Stages{RstVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];
endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: reassembles MSB-first words, indexes them within the configuration
// table, flags aborted frames and echoes the previous word on spi_sdo.
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = DataWDef,
  parameter int unsigned NUM_WORDS   = NumWordsDef,
  parameter int unsigned IDX_W       = IdxWDef,
  parameter int unsigned SYNC_STAGES = SyncStagesDef
) (
  input  logic         sclk,
  input  logic         rst,
  spi_slave_rx_if.slave bus
);
  localparam int unsigned BitW   = $clog2(DATA_W);
  localparam int unsigned FlushW = $clog2(SYNC_STAGES + 1);

  logic clk_s, csn_s, sdi_s;
  logic clk_q, csn_q;
  logic clk_rise, clk_fall, csn_fall, csn_rise, flush_done;

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [IDX_W-1:0]  rx_index_q, rx_index_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;
  logic [DATA_W-1:0] echo_q, echo_d;
  logic              sdo_q, sdo_d;
  logic [FlushW-1:0] flush_q, flush_d;
  logic              armed_q, armed_d;

  spi_slave_rx_sync #(.Stages(SYNC_STAGES), .RstVal(SyncRstClk)) u_sync_clk (
    .clk_i(sclk), .rst_i(rst), .d_i(bus.spi_clk), .q_o(clk_s)
  );
  spi_slave_rx_sync #(.Stages(SYNC_STAGES), .RstVal(SyncRstCsn)) u_sync_csn (
    .clk_i(sclk), .rst_i(rst), .d_i(bus.spi_csn), .q_o(csn_s)
  );
  spi_slave_rx_sync #(.Stages(SYNC_STAGES), .RstVal(SyncRstSdi)) u_sync_sdi (
    .clk_i(sclk), .rst_i(rst), .d_i(bus.spi_sdi), .q_o(sdi_s)
  );

  assign clk_rise   = clk_s & ~clk_q;
  assign clk_fall   = ~clk_s & clk_q;
  assign csn_fall   = ~csn_s & csn_q;
  assign csn_rise   = csn_s & ~csn_q;
  assign flush_done = (flush_q == FlushW'(SYNC_STAGES));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_index_d  = rx_index_q;
    rx_done_d   = rx_done_q;
    frame_err_d = 1'b0;
    echo_d      = echo_q;
    sdo_d       = sdo_q;
    flush_d     = flush_done ? flush_q : flush_q + FlushW'(1);
    // A frame already running when reset lifts is ignored until csn is seen high.
    armed_d     = armed_q | (flush_done & csn_s);

    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        sdo_d     = 1'b0;
        if (armed_q && csn_fall) begin
          state_d = StShift;
          shift_d = '0;
          sdo_d   = rx_data_q[DATA_W-1];
          echo_d  = {rx_data_q[DATA_W-2:0], 1'b0};
        end
      end
      StShift: begin
        if (clk_fall) begin
          sdo_d  = echo_q[DATA_W-1];
          echo_d = {echo_q[DATA_W-2:0], 1'b0};
        end
        if (clk_rise) begin
          shift_d = {shift_q[DATA_W-2:0], sdi_s};
          if (bit_cnt_q == BitW'(DATA_W - 1)) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
            rx_index_d = word_cnt_q;
            echo_d     = shift_d;
            bit_cnt_d  = '0;
            if (word_cnt_q == IDX_W'(NUM_WORDS - 1)) begin
              word_cnt_d = '0;
              rx_done_d  = 1'b1;
            end else begin
              word_cnt_d = word_cnt_q + IDX_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
        // A word completing in the same cycle leaves bit_cnt_d at zero, so no error.
        if (csn_rise) begin
          state_d     = StIdle;
          frame_err_d = (bit_cnt_d != '0);
          bit_cnt_d   = '0;
          shift_d     = '0;
          sdo_d       = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      clk_q       <= SyncRstClk;
      csn_q       <= SyncRstCsn;
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_index_q  <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      echo_q      <= '0;
      sdo_q       <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      clk_q       <= clk_s;
      csn_q       <= csn_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_index_q  <= rx_index_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      echo_q      <= echo_d;
      sdo_q       <= sdo_d;
      flush_q     <= flush_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.spi_sdo   = sdo_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_index  = rx_index_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI slave receiver, the far end of the spi_ctrl DAC-configuration master link. It samples spi_clk, spi_csn and spi_sdi in the sclk domain and reassembles MSB-first words. It presents each word with an index and a valid pulse, flags aborted frames, and raises a done flag after the full configuration table has arrived. It serves as an on-chip loopback checker and as a DAC register-file model.

Parameters:
DATA_W, 16, bits per SPI word
NUM_WORDS, 32, words in one full configuration table
IDX_W, 5, width of rx_index (clog2 NUM_WORDS)
SYNC_STAGES, 2, synchronizer depth for spi_clk/spi_csn/spi_sdi (minimum 2)

Ports:
sclk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
spi_clk  in  1  SPI clock from master, idles low, data launched on falling edge
spi_csn  in  1  chip select, active low
spi_sdi  in  1  serial data from master, MSB first
spi_sdo  out  1  echo of previously received word, MSB first (diagnostic)
rx_data  out  DATA_W  last complete word
rx_valid  out  1  one-cycle pulse, rx_data/rx_index valid
rx_index  out  IDX_W  position of rx_data in table, 0..NUM_WORDS-1
rx_done  out  1  sticky, NUM_WORDS words received
frame_err  out  1  one-cycle pulse, csn deasserted mid-word

Behaviour:
- Interface decision: one clock (sclk); reset is asynchronous and active-high (rst). All flops are reset asynchronously by rst.
- Reset values: spi_sdo 0, rx_data 0, rx_valid 0, rx_index 0, rx_done 0, frame_err 0, shift reg 0, bit_cnt 0, word_cnt 0, echo reg 0.
- Synchronizer reset values: clk 0, csn 1, sdi 0. One extra flop on synced clk and synced csn drives edge detection.
- Constraint: spi_clk high and low phases must each be ≥2 sclk periods, so spi_clk ≤ sclk/4 (12.5 MHz). spi_sdo is usable only for spi_clk ≤ sclk/8.
- States:
  - IDLE (synced csn=1): bit_cnt held 0; spi_clk edges ignored.
  - SHIFT (synced csn=0): entered on the synced csn falling edge. On entry, echo reg is loaded and its MSB is driven on spi_sdo.
- Sampling: on each synced spi_clk rising edge in SHIFT:
  - shift <= {shift[DATA_W-2:0], sdi_s}; bit_cnt++.
- Word completion: on the rising edge where bit_cnt==DATA_W-1:
  - rx_data <= assembled word; rx_valid=1 for exactly one cycle; rx_index <= word_cnt.
  - echo reg <= assembled word; bit_cnt <= 0.
  - word_cnt <= word_cnt+1, wrapping NUM_WORDS-1 -> 0.
  - If word_cnt==NUM_WORDS-1: rx_done <= 1, held until rst.
- Latency: rx_valid is high after the SYNC_STAGES-th sclk edge following the sclk edge that first samples the 16th raw spi_clk high.
- Back-to-back words within one csn-low window are legal; no gap is required.
- spi_sdo: on each synced spi_clk falling edge in SHIFT, echo reg shifts left and its MSB is driven. In IDLE, spi_sdo is 0.
- Frame abort: synced csn rising edge with bit_cnt≠0:
  - frame_err pulses 1 cycle; partial word discarded; bit_cnt <= 0; word_cnt unchanged.
  - With bit_cnt==0: no error.
- Simultaneous events: 16th rising edge and csn rising edge in the same sclk cycle: the word completes (rx_valid), with no frame_err.
- No backpressure: a consumer that misses rx_valid loses that word.
- Reset mid-frame: all state clears immediately; a partial word is discarded. After reset release, receive resumes only after the next synced csn falling edge, so a frame already in progress is ignored until csn rises.

Decomposition:
- spi_pkg: DATA_W, NUM_WORDS, IDX_W defaults; spi_clk idle level; sync reset-value constants.
- Sub-module spi_sync: SYNC_STAGES-deep flop chain with parameterised reset value. Instantiated three times.

Test Plan:
- 32 words from dac_ini_16_32.mif sent by spi_ctrl at sclk/4 -> 32 rx_valid pulses; rx_index 0..31 in order; each rx_data equals send_mem[i]; rx_done rises with the 32nd pulse.
- Single word 16'hA5C3, csn low -> rx_data=16'hA5C3, rx_valid width 1 cycle, rx_index=0, frame_err never asserted.
- csn raised after 9 bits, then full word 16'h1234 -> frame_err one pulse; next rx_data=16'h1234 with rx_index=0.
- 34 words -> rx_done stays 1; word 33 reports rx_index=0 and word 34 reports rx_index=1.
- Words 16'hBEEF then 16'h0001 in one csn window at sclk/8 -> spi_sdo shifts out 1011111011101111 during the second word.
- rst pulsed after 7 bits of word 3 -> all outputs return to reset values; a fresh 16'h00FF frame yields rx_index=0, rx_done=0.
